// File: rtl/bus_hold_arbiter_pkg.sv
// bus_hold_arbiter_pkg
//   Shared types and defaults for the 8088 HOLD/HLDA bus arbiter.
//   arb_state_t              : arbiter FSM state encoding
//   ARB_N_REQ_DEFAULT        : default number of bus requesters
//   ARB_MAX_TENURE_DEFAULT   : default grant-length limit (TENURE_LIMIT_EN builds)
package bus_hold_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_HLDA, GRANT, RELEASE} arb_state_t;

    localparam int ARB_N_REQ_DEFAULT      = 4;
    localparam int ARB_MAX_TENURE_DEFAULT = 64;
endpackage

// File: rtl/bus_hold_arbiter_picker.sv
// rr_priority_picker
//   Purely combinational round-robin picker. Searches req upward starting
//   at last+1, wrapping modulo N_REQ, and reports the first set bit.
//   Ports:
//     req    in  N_REQ  request vector
//     last   in  ID_W   index of the previous winner
//     valid  out 1      any request present
//     winner out ID_W   selected index (0 when valid=0)
module rr_priority_picker
    import bus_hold_arbiter_pkg::*;
#(
    parameter int N_REQ = ARB_N_REQ_DEFAULT,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic             valid,
    output logic [ID_W-1:0]  winner
);

    logic [ID_W-1:0] idx;

    // Walk the search order backwards so the final overwrite is the
    // candidate closest to last+1; avoids a break/found flag.
    always_comb begin
        valid  = |req;
        winner = '0;
        idx    = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = ID_W'((int'(last) + i) % N_REQ);
            if (req[idx]) winner = idx;
        end
    end

endmodule

// File: rtl/bus_hold_arbiter.sv
// bus_hold_arbiter
//   Shares the 8088 local bus between N_REQ requesters using HOLD/HLDA.
//   Flow: IDLE -> WAIT_HLDA -> GRANT -> RELEASE -> IDLE, round-robin winner.
//   Optional macro TENURE_LIMIT_EN: caps a grant at MAX_TENURE cycles.
//   Ports:
//     CLK      in   system clock
//     RESET    in   synchronous active-high reset
//     REQ      in   N_REQ level requests
//     HLDA     in   hold acknowledge from the CPU
//     HOLD     out  hold request to the CPU
//     GNT      out  one-hot grant
//     GNT_ID   out  index of current/last winner
//     BUSY     out  high whenever the arbiter is not idle
//     ARB_ERR  out  sticky protocol error (HLDA lost during GRANT)
//   All outputs are registered.
module bus_hold_arbiter
    import bus_hold_arbiter_pkg::*;
#(
    parameter int N_REQ      = ARB_N_REQ_DEFAULT,
    parameter int MAX_TENURE = ARB_MAX_TENURE_DEFAULT,
    parameter int ID_W       = $clog2(N_REQ)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_REQ-1:0] REQ,
    input  logic             HLDA,
    output logic             HOLD,
    output logic [N_REQ-1:0] GNT,
    output logic [ID_W-1:0]  GNT_ID,
    output logic             BUSY,
    output logic             ARB_ERR
);

    arb_state_t       state_q, state_d;
    logic             hold_d, busy_d, err_d;
    logic [N_REQ-1:0] gnt_d;
    logic [ID_W-1:0]  id_d;
    logic [ID_W-1:0]  last_q, last_d;
    // Winner withdrew its request while we were still waiting for HLDA.
    logic             wd_q, wd_d;
    logic             expire;
    logic             pick_valid;
    logic [ID_W-1:0]  pick_winner;

`ifdef TENURE_LIMIT_EN
    localparam int TEN_W = $clog2(MAX_TENURE + 1);
    logic [TEN_W-1:0] ten_q, ten_d;
    assign expire = (ten_q == TEN_W'(MAX_TENURE - 1));
`else
    assign expire = 1'b0;
`endif

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req    (REQ),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = HOLD;
        gnt_d   = GNT;
        id_d    = GNT_ID;
        err_d   = ARB_ERR;
        last_d  = last_q;
        wd_d    = wd_q;
`ifdef TENURE_LIMIT_EN
        ten_d   = ten_q;
`endif
        case (state_q)
            IDLE: begin
                wd_d = 1'b0;
                if (pick_valid) begin
                    state_d = WAIT_HLDA;
                    id_d    = pick_winner;
                    hold_d  = 1'b1;
                end
            end
            WAIT_HLDA: begin
                if (!REQ[GNT_ID]) wd_d = 1'b1;
                if (HLDA) begin
                    // The CPU has already let go of the bus; finish the
                    // handshake even if nobody wants it any more.
                    if (wd_q || !REQ[GNT_ID]) begin
                        state_d = RELEASE;
                        hold_d  = 1'b0;
                    end else begin
                        state_d        = GRANT;
                        gnt_d          = '0;
                        gnt_d[GNT_ID]  = 1'b1;
                        last_d         = GNT_ID;
`ifdef TENURE_LIMIT_EN
                        ten_d          = '0;
`endif
                    end
                end
            end
            GRANT: begin
                if (!HLDA) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    gnt_d   = '0;
                    hold_d  = 1'b0;
                end else if (!REQ[GNT_ID] || expire) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    hold_d  = 1'b0;
                end else begin
`ifdef TENURE_LIMIT_EN
                    if (ten_q != TEN_W'(MAX_TENURE)) ten_d = ten_q + 1'b1;
`endif
                end
            end
            RELEASE: begin
                if (!HLDA) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            HOLD    <= 1'b0;
            GNT     <= '0;
            GNT_ID  <= '0;
            BUSY    <= 1'b0;
            ARB_ERR <= 1'b0;
            last_q  <= ID_W'(N_REQ - 1);
            wd_q    <= 1'b0;
`ifdef TENURE_LIMIT_EN
            ten_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            HOLD    <= hold_d;
            GNT     <= gnt_d;
            GNT_ID  <= id_d;
            BUSY    <= busy_d;
            ARB_ERR <= err_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
`ifdef TENURE_LIMIT_EN
            ten_q   <= ten_d;
`endif
        end
    end

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// tb_bus_hold_arbiter
//   Directed scenarios followed by randomized requests and a randomized CPU
//   HLDA responder, all checked every cycle against a phase-level model.
module tb_bus_hold_arbiter;
    localparam int N = 4;
`ifdef TENURE_LIMIT_EN
    localparam int MAX_T = 8;
`else
    localparam int MAX_T = 64;
`endif

    logic         CLK, RESET, HLDA, HOLD, BUSY, ARB_ERR;
    logic [N-1:0] REQ, GNT;
    logic [1:0]   GNT_ID;

    int checks = 0, passes = 0, fails = 0;

    // Model: phase 0 = CPU owns bus, 1 = asking CPU, 2 = requester owns bus,
    // 3 = handing back to CPU.
    int m_phase = 0, m_last = N - 1, m_id = 0, m_ten = 0;
    bit m_err = 0, m_cancel = 0;

    bus_hold_arbiter #(.N_REQ(N), .MAX_TENURE(MAX_T)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .HLDA(HLDA), .HOLD(HOLD),
        .GNT(GNT), .GNT_ID(GNT_ID), .BUSY(BUSY), .ARB_ERR(ARB_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    task automatic model_step();
        bit expire;
        expire = 1'b0;
`ifdef TENURE_LIMIT_EN
        expire = (m_ten == MAX_T - 1);
`endif
        if (RESET) begin
            m_phase = 0; m_last = N - 1; m_id = 0; m_err = 0; m_cancel = 0; m_ten = 0;
        end else begin
            case (m_phase)
                0: if (REQ != 0) begin
                    m_id = pick(REQ, m_last); m_cancel = 0; m_phase = 1;
                end
                1: begin
                    if (!REQ[m_id]) m_cancel = 1;
                    if (HLDA) begin
                        if (m_cancel) m_phase = 3;
                        else begin m_phase = 2; m_last = m_id; m_ten = 0; end
                    end
                end
                2: if (!HLDA) begin m_err = 1; m_phase = 0; end
                   else if (!REQ[m_id] || expire) m_phase = 3;
                   else m_ten++;
                3: if (!HLDA) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    endtask

    // One clock: advance the model on the same sampled inputs as the DUT,
    // then compare every output shortly after the edge.
    task automatic tick();
        logic [N-1:0] eg;
        @(posedge CLK);
        model_step();
        #1;
        eg = (m_phase == 2) ? N'(1 << m_id) : '0;
        chk("m_hold", 32'(HOLD), 32'(m_phase == 1 || m_phase == 2));
        chk("m_gnt", 32'(GNT), 32'(eg));
        chk("m_id", 32'(GNT_ID), 32'(m_id));
        chk("m_busy", 32'(BUSY), 32'(m_phase != 0));
        chk("m_err", 32'(ARB_ERR), 32'(m_err));
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            tick();
            HLDA = HOLD;
            if (!BUSY && !HLDA) break;
        end
        chk("drain_busy", 32'(BUSY), 32'd0);
    endtask

    initial begin
        int ord[5];
        int n, gcnt, restore, bad_gap, cnt;
        bit prev_g, saw_idle, gseen;

        RESET = 1'b1; REQ = '0; HLDA = 1'b0;
        tick();
        RESET = 1'b0;
        chk("rst_hold", 32'(HOLD), 32'd0);
        chk("rst_gnt", 32'(GNT), 32'd0);
        chk("rst_id", 32'(GNT_ID), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_err", 32'(ARB_ERR), 32'd0);

        // Single request
        REQ = 4'b0100; tick();
        chk("single_hold", 32'(HOLD), 32'd1);
        chk("single_id", 32'(GNT_ID), 32'd2);
        tick(); tick();
        chk("single_nogntyet", 32'(GNT), 32'd0);
        HLDA = 1'b1; tick();
        chk("single_gnt", 32'(GNT), 32'b0100);
        for (int i = 0; i < 5; i++) tick();
        chk("single_gnt_hold", 32'(GNT), 32'b0100);
        REQ = '0; tick();
        chk("single_rel_gnt", 32'(GNT), 32'd0);
        chk("single_rel_hold", 32'(HOLD), 32'd0);
        chk("single_rel_busy", 32'(BUSY), 32'd1);
        HLDA = 1'b0; tick();
        chk("single_idle_busy", 32'(BUSY), 32'd0);

        // Round robin with all requesting
        RESET = 1'b1; tick(); RESET = 1'b0;
        REQ = 4'b1111;
        n = 0; gcnt = 0; restore = -1; bad_gap = 0; prev_g = 0; saw_idle = 1;
        for (int cyc = 0; cyc < 300 && n < 5; cyc++) begin
            tick();
            HLDA = HOLD;
            if (restore >= 0) begin REQ[restore] = 1'b1; restore = -1; end
            if (!BUSY) saw_idle = 1;
            if (GNT != 0) begin
                if (!prev_g) begin
                    ord[n] = int'(GNT_ID); n++; gcnt = 0;
                    if (!saw_idle) bad_gap++;
                    saw_idle = 0;
                end
                gcnt++;
                if (gcnt == 3) begin REQ[GNT_ID] = 1'b0; restore = int'(GNT_ID); end
            end
            prev_g = (GNT != 0);
        end
        chk("rr_count", 32'(n), 32'd5);
        for (int i = 0; i < 5; i++) chk("rr_order", 32'(ord[i]), 32'(i % 4));
        chk("rr_idle_gap", 32'(bad_gap), 32'd0);
        REQ = '0;
        drain();

        // Withdraw before acknowledge
        gseen = 0;
        REQ = 4'b0001; tick();
        chk("wd_hold", 32'(HOLD), 32'd1);
        REQ = '0;
        for (int i = 0; i < 4; i++) begin tick(); if (GNT != 0) gseen = 1; end
        HLDA = 1'b1; tick(); if (GNT != 0) gseen = 1;
        chk("wd_hold_fall", 32'(HOLD), 32'd0);
        chk("wd_busy", 32'(BUSY), 32'd1);
        tick(); if (GNT != 0) gseen = 1;
        chk("wd_wait_hlda", 32'(BUSY), 32'd1);
        HLDA = 1'b0; tick();
        chk("wd_idle", 32'(BUSY), 32'd0);
        chk("wd_never_gnt", 32'(gseen), 32'd0);

        // Protocol error
        REQ = 4'b0010; tick();
        HLDA = 1'b1; tick();
        chk("err_gnt", 32'(GNT), 32'b0010);
        tick();
        HLDA = 1'b0; tick();
        REQ = '0;
        chk("err_gnt0", 32'(GNT), 32'd0);
        chk("err_hold0", 32'(HOLD), 32'd0);
        chk("err_flag", 32'(ARB_ERR), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("err_sticky", 32'(ARB_ERR), 32'd1);
        RESET = 1'b1; tick(); RESET = 1'b0;
        chk("err_cleared", 32'(ARB_ERR), 32'd0);

        // Reset in the middle of a grant
        REQ = 4'b0010; tick();
        HLDA = 1'b1; tick();
        chk("rstg_gnt", 32'(GNT), 32'b0010);
        RESET = 1'b1; tick(); RESET = 1'b0;
        chk("rstg_gnt0", 32'(GNT), 32'd0);
        chk("rstg_hold0", 32'(HOLD), 32'd0);
        chk("rstg_busy0", 32'(BUSY), 32'd0);
        HLDA = 1'b0; REQ = 4'b0011; tick();
        chk("rstg_id", 32'(GNT_ID), 32'd0);
        HLDA = 1'b1; tick();
        chk("rstg_gnt_r0", 32'(GNT), 32'b0001);

        // Tenure behaviour with a streaming requester
`ifdef TENURE_LIMIT_EN
        cnt = 1;
        for (int i = 0; i < 50 && GNT == 4'b0001; i++) begin
            tick(); HLDA = HOLD;
            if (GNT == 4'b0001) cnt++;
        end
        chk("ten_len", 32'(cnt), 32'd8);
        for (int i = 0; i < 20 && GNT == 0; i++) begin tick(); HLDA = HOLD; end
        chk("ten_next", 32'(GNT), 32'b0010);
`else
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            tick(); HLDA = HOLD;
            if (GNT == 4'b0001) cnt++;
        end
        chk("ten_unlimited", 32'(cnt), 32'd80);
`endif
        REQ = '0;
        drain();

        // Randomized traffic with a sluggish CPU that occasionally drops HLDA
        RESET = 1'b1; tick(); RESET = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            if (HOLD && !HLDA && $urandom_range(0, 2) == 0) HLDA = 1'b1;
            else if (!HOLD && HLDA && $urandom_range(0, 1) == 0) HLDA = 1'b0;
            else if (HOLD && HLDA && GNT != 0 && $urandom_range(0, 60) == 0) HLDA = 1'b0;
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 5) == 0) REQ[b] = ~REQ[b];
            RESET = ($urandom_range(0, 299) == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/bus_hold_arbiter.md
Name: bus_hold_arbiter

Overview:
Shares the 8088 local bus (AD/A, IOM, RD, WR) between N_REQ DMA-style requesters. It uses the processor HOLD/HLDA handshake. The block drives HOLD to the Intel8088 model, waits for HLDA, grants exactly one requester at a time in round-robin order, and returns the bus to the CPU when the owner finishes. It sits in top beside the address latch and chip-select decode, and is clocked by the system CLK.

Parameters:
N_REQ, 4, number of bus requesters (2..8)
MAX_TENURE, 64, maximum GRANT cycles per ownership (used only with TENURE_LIMIT_EN)
ID_W, $clog2(N_REQ), width of GNT_ID

Ports:
CLK  input  1  system clock; all state changes on posedge
RESET  input  1  synchronous, active-high reset
REQ  input  N_REQ  level request per requester; held high while bus is wanted
HLDA  input  1  hold acknowledge from Intel8088
HOLD  output  1  hold request to Intel8088
GNT  output  N_REQ  one-hot bus grant; at most one bit set
GNT_ID  output  ID_W  index of current/last winner
BUSY  output  1  high whenever state != IDLE
ARB_ERR  output  1  sticky protocol-error flag

Behaviour:
- All outputs are registered. Reset drives HOLD=0, GNT=0, GNT_ID=0, BUSY=0, ARB_ERR=0, state=IDLE and last_grant=N_REQ-1, so requester 0 has first priority after reset.
- State machine: IDLE -> WAIT_HLDA -> GRANT -> RELEASE -> IDLE.
- IDLE: HOLD=0, GNT=0.
  - If |REQ is sampled at edge t, the winner is the first set REQ bit searching upward from last_grant+1, with modulo-N_REQ wrap.
  - The winner is latched into GNT_ID; HOLD=1 and BUSY=1 from edge t+1.
- WAIT_HLDA: HOLD=1, GNT=0.
  - HLDA=1 sampled at edge u -> GRANT. GNT[GNT_ID]=1 from u+1, and last_grant<=GNT_ID.
  - If the winner's REQ drops before HLDA, stay in WAIT_HLDA until HLDA=1, then go to RELEASE with no grant issued (the 8088 must not be left mid-handshake).
  - There is no timeout in WAIT_HLDA.
- GRANT: HOLD=1, GNT one-hot, tenure counter increments each cycle starting from 0.
  - Winner's REQ=0 sampled at edge v -> RELEASE; GNT=0 and HOLD=0 from v+1.
  - Other requesters' REQ changes are ignored until the next IDLE arbitration; there is no preemption.
- RELEASE: HOLD=0, GNT=0; wait for HLDA=0, then go to IDLE. A new arbitration needs at least one IDLE cycle, so the CPU always gets a bus window between owners.
- Protocol error: HLDA=0 sampled while in GRANT.
  - Go to IDLE immediately, GNT=0 and HOLD=0 next cycle.
  - ARB_ERR=1 and stays set until RESET.
  - last_grant is still updated.
- Simultaneous events: in GRANT, REQ drop and tenure expiry on the same edge give a single RELEASE transition.
- Reset mid-operation: outputs return to reset values on the next edge regardless of HLDA. The CPU model then sees HOLD fall.
- Counter: the tenure counter width is $clog2(MAX_TENURE+1) and saturates; it never wraps.

Optional Feature:
Macro TENURE_LIMIT_EN.
- When defined: in GRANT, the tenure count reaching MAX_TENURE-1 forces RELEASE on that edge even though REQ is still high. The requester must re-request and competes round-robin again, so a streaming requester cannot starve the CPU.
- When undefined: the counter logic is removed and ownership lasts until REQ drops.

Decomposition:
- my_pkg gains:
  - typedef enum logic [1:0] arb_state_t {IDLE, WAIT_HLDA, GRANT, RELEASE};
  - localparam ARB_N_REQ_DEFAULT=4 and ARB_MAX_TENURE_DEFAULT=64.
- One sub-module, rr_priority_picker: purely combinational. Inputs are req[N_REQ] and last[ID_W]; outputs are valid and winner[ID_W]. It is reused by any future arbiter.

Test Plan:
- Single request: REQ=4'b0100 in IDLE at edge 10 -> HOLD=1 at 11; HLDA=1 at 13 -> GNT=4'b0100, GNT_ID=2 at 14; REQ=0 at 20 -> GNT=0, HOLD=0 at 21; HLDA=0 -> BUSY=0 one cycle later.
- Round-robin: REQ=4'b1111 held, each owner drops REQ for one cycle after 3 GRANT cycles -> grant order 0,1,2,3,0 with at least one IDLE cycle between owners.
- Withdraw before ack: REQ=4'b0001 then REQ=0 while in WAIT_HLDA; HLDA=1 after 4 cycles -> GNT never asserted, HOLD falls the next cycle, FSM returns to IDLE after HLDA=0.
- Protocol error: HLDA forced to 0 during GRANT -> GNT=0 and HOLD=0 next cycle, ARB_ERR=1 and stays set until RESET=1 for one cycle.
- Reset mid-GRANT: RESET=1 for one edge while GNT=4'b0010 -> all outputs 0 next edge; next REQ=4'b0011 grants requester 0.
- TENURE_LIMIT_EN with MAX_TENURE=8: REQ=4'b0011 held -> requester 0 granted exactly 8 cycles, then release, then requester 1 granted; without the macro, requester 0 holds GNT indefinitely.
